fp_align_seq: RTL and testbench
===============================

Name: fp_align_seq

Overview:
- Pre-add alignment stage of the FP32 add/subtract datapath. It sits upstream of the post-add normalization stage.
- Unpacks two IEEE-754 single operands and orders them by magnitude.
- Right-shifts the smaller significand by the exponent difference, one bit per cycle, into a guard/round/sticky extended field.
- Hands the adder aligned significands, the base exponent, the result sign and the effective operation.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width. The significand is MAN_W+1 bits.
- SHIFT_CAP, 26, maximum shift count. It equals MAN_W+3; any larger difference is clamped to it.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a  input  32  operand A, FP32.
- b  input  32  operand B, FP32.
- op  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  aligned result valid.
- out_ready  input  1  downstream accepts result.
- man_big  output  27  larger significand, {hidden, frac, 3'b000}.
- man_small  output  27  aligned smaller significand, {sig, G, R, S}.
- exp_base  output  8  exponent of the larger operand (effective exponent).
- sign_big  output  1  sign of the larger operand after applying op.
- eff_sub  output  1  effective subtraction, a.sign ^ b.sign ^ op.
- swapped  output  1  1 when B is the larger operand.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). While rst_n is low, the FSM is in IDLE and every output register is 0. in_ready follows the state, so it is 1 once in IDLE. Reset asserted mid-SHIFT or in HOLD aborts immediately and discards the operation.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: in_ready=0, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept is in_valid & in_ready at a rising edge. At accept the block:
  - Unpacks each operand. Biased exponent 0 means hidden bit 0 and effective exponent 1 (denormal). Otherwise the hidden bit is 1 and the exponent is unchanged.
  - Picks the larger operand by comparing {eff_exp, significand}. On an exact tie, A is larger and swapped=0.
  - Computes diff = exp_big - exp_small (8-bit unsigned, never negative) and cnt = min(diff, SHIFT_CAP).
  - Registers man_big and man_small = {sig_small, 3'b000}, plus exp_base, sign_big, eff_sub and swapped. sign_big = A.sign if A is larger, else B.sign ^ op.
  - Goes to HOLD if cnt==0, else to SHIFT.
- SHIFT, each cycle:
  - man_small <= {1'b0, man_small[26:2], man_small[1] | man_small[0]}. Sticky is ORed, never lost.
  - cnt decrements. When cnt reaches 1, go to HOLD on the same edge.
- Latency: out_valid rises exactly 1+cnt cycles after the accept edge.
- HOLD: all outputs are held stable while out_ready=0. On out_valid & out_ready, go to IDLE; out_valid drops next cycle. There is no overlap: a new accept can happen only from IDLE, at the earliest one cycle after the output handshake.
- Clamp: at cnt=26, bit 26 lands in the sticky bit. man_small is 27'h1 for any nonzero small operand, and 0 if the small operand is zero.
- Zero operands: these are handled naturally. If both are zero, the outputs are zero with exp_base=1.
- Special values: exponent 255 (Inf/NaN) is passed through unmodified, with its hidden bit set to 1. Special-case handling belongs to a separate unit.
- Output and the ready/valid logic are registered; there are no combinational input-to-output paths.

Decomposition:
- fp_pkg holds:
  - EXP_W, MAN_W, GRS_W=3, SIG_W=MAN_W+1, SHIFT_CAP.
  - The FP32 field slice constants.
  - The state enum {IDLE, SHIFT, HOLD}.
  - An unpacked-operand typedef {sign, eff_exp, sig}.
- Sub-module fp_unpack: purely combinational, FP32 word to {sign, eff_exp, sig}. It handles the denormal rule and is instanced twice.

Test Plan:
1. a=0x3F800000, b=0x3F000000, op=0 → accept, then out_valid 2 cycles later. Expected outputs: man_big=27'h4000000, man_small=27'h2000000, exp_base=8'h7F, eff_sub=0, swapped=0, sign_big=0.
2. a=0x3F000000, b=0x3F800000, op=1 → swapped=1, sign_big=1, eff_sub=1, exp_base=8'h7F, man_small=27'h2000000.
3. a=0x4B800000, b=0x3F800001 (diff 24) → out_valid 25 cycles after accept. Expected: man_small=27'h5 (bit2 set, sticky from the dropped LSB), exp_base=8'h97.
4. a=0x64000000 (exp 200), b=0x3F800000 → clamp to 26 shifts: man_small=27'h1, out_valid 27 cycles after accept. Same case with b=0x00000000 → man_small=0.
5. a=0x00800000, b=0x00000001 (denormal) → diff 0, out_valid 1 cycle after accept. Expected: man_small=27'h8, exp_base=1. Then hold out_ready=0 for 5 cycles → outputs stable and in_ready=0; raise out_ready → in_ready=1 next cycle.
6. Assert rst_n=0 three cycles into SHIFT → out_valid=0 and all outputs 0 immediately (asynchronously). After release, in_ready=1 and a fresh op completes correctly.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared widths, FP32 field positions, FSM states and the unpacked-operand
// type for the FP32 pre-add alignment stage.
package fp_pkg;

  localparam int EXP_W     = 8;
  localparam int MAN_W     = 23;
  localparam int GRS_W     = 3;
  localparam int SIG_W     = MAN_W + 1;
  localparam int SHIFT_CAP = MAN_W + 3;
  localparam int EXT_W     = SIG_W + GRS_W;
  localparam int CNT_W     = 5;
  localparam int FP_W      = 1 + EXP_W + MAN_W;

  localparam int SIGN_BIT  = FP_W - 1;
  localparam int EXP_MSB   = FP_W - 2;
  localparam int EXP_LSB   = MAN_W;
  localparam int MAN_MSB   = MAN_W - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] eff_exp;
    logic [SIG_W-1:0] sig;
  } fp_unp_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational FP32 unpack: a zero biased exponent is a denormal with a
// cleared hidden bit and an effective exponent of 1.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [FP_W-1:0] word,
  output fp_unp_t         unp
);

  logic [EXP_W-1:0] exp_s;
  logic [MAN_W-1:0] frac_s;
  logic             denorm_s;

  assign exp_s    = word[EXP_MSB:EXP_LSB];
  assign frac_s   = word[MAN_MSB:0];
  assign denorm_s = (exp_s == {EXP_W{1'b0}});

  // Exponent 255 needs no special case: it keeps its value and a set hidden bit.
  assign unp.sign    = word[SIGN_BIT];
  assign unp.eff_exp = denorm_s ? {{(EXP_W-1){1'b0}}, 1'b1} : exp_s;
  assign unp.sig     = {~denorm_s, frac_s};

endmodule

// File: rtl/fp_align_seq.sv
// FP32 add/sub alignment: orders operands by magnitude and shifts the smaller
// significand right one bit per cycle into a guard/round/sticky field.
module fp_align_seq
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  a,
  input  logic [FP_W-1:0]  b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXT_W-1:0] man_big,
  output logic [EXT_W-1:0] man_small,
  output logic [EXP_W-1:0] exp_base,
  output logic             sign_big,
  output logic             eff_sub,
  output logic             swapped
);

  fp_unp_t          unp_a_s;
  fp_unp_t          unp_b_s;
  fp_unp_t          big_s;
  fp_unp_t          small_s;
  logic             b_larger_s;
  logic [EXP_W-1:0] diff_s;
  logic [CNT_W-1:0] cnt_init_s;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             out_valid_r;
  logic [EXT_W-1:0] man_big_r;
  logic [EXT_W-1:0] man_small_r;
  logic [EXP_W-1:0] exp_base_r;
  logic             sign_big_r;
  logic             eff_sub_r;
  logic             swapped_r;

  fp_unpack u_unpack_a (.word(a), .unp(unp_a_s));
  fp_unpack u_unpack_b (.word(b), .unp(unp_b_s));

  // An exact tie keeps A as the larger operand.
  assign b_larger_s = {unp_b_s.eff_exp, unp_b_s.sig} > {unp_a_s.eff_exp, unp_a_s.sig};
  assign big_s      = b_larger_s ? unp_b_s : unp_a_s;
  assign small_s    = b_larger_s ? unp_a_s : unp_b_s;
  assign diff_s     = big_s.eff_exp - small_s.eff_exp;
  assign cnt_init_s = (diff_s > EXP_W'(SHIFT_CAP)) ? CNT_W'(SHIFT_CAP) : diff_s[CNT_W-1:0];

  // Control FSM, shift counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
      man_big_r   <= {EXT_W{1'b0}};
      man_small_r <= {EXT_W{1'b0}};
      exp_base_r  <= {EXP_W{1'b0}};
      sign_big_r  <= 1'b0;
      eff_sub_r   <= 1'b0;
      swapped_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            man_big_r   <= {big_s.sig, {GRS_W{1'b0}}};
            man_small_r <= {small_s.sig, {GRS_W{1'b0}}};
            exp_base_r  <= big_s.eff_exp;
            sign_big_r  <= b_larger_s ? (unp_b_s.sign ^ op) : unp_a_s.sign;
            eff_sub_r   <= unp_a_s.sign ^ unp_b_s.sign ^ op;
            swapped_r   <= b_larger_s;
            cnt_r       <= cnt_init_s;
            if (cnt_init_s == {CNT_W{1'b0}}) begin
              state_r     <= HOLD;
              out_valid_r <= 1'b1;
            end else begin
              state_r     <= SHIFT;
            end
          end
        end
        SHIFT: begin
          // The two low bits fold into sticky so no dropped one is lost.
          man_small_r <= {1'b0, man_small_r[EXT_W-1:2], man_small_r[1] | man_small_r[0]};
          cnt_r       <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_r     <= HOLD;
            out_valid_r <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign man_big   = man_big_r;
  assign man_small = man_small_r;
  assign exp_base  = exp_base_r;
  assign sign_big  = sign_big_r;
  assign eff_sub   = eff_sub_r;
  assign swapped   = swapped_r;

endmodule

// File: tb/tb_fp_align_seq.sv
// Scoreboard bench for fp_align_seq: directed vectors push expected results,
// a negedge monitor checks latency and fields at each output handshake.
module tb_fp_align_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [26:0] man_big;
  logic [26:0] man_small;
  logic [7:0]  exp_base;
  logic        sign_big;
  logic        eff_sub;
  logic        swapped;

  typedef struct {
    logic [26:0] mb;
    logic [26:0] ms;
    logic [7:0]  eb;
    logic        sb;
    logic        es;
    logic        sw;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   seen = 1'b0;

  fp_align_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .man_big(man_big), .man_small(man_small), .exp_base(exp_base),
    .sign_big(sign_big), .eff_sub(eff_sub), .swapped(swapped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: latency on first sight of out_valid, field compare on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        chk("out_valid_expected", q.size() != 0, 1);
        if (q.size() != 0) chk("latency", cyc - q[0].acc + 1, q[0].lat);
      end
      if (out_valid && out_ready && q.size() != 0) begin
        chk("man_big", man_big, q[0].mb);
        chk("man_small", man_small, q[0].ms);
        chk("exp_base", exp_base, q[0].eb);
        chk("sign_big", sign_big, q[0].sb);
        chk("eff_sub", eff_sub, q[0].es);
        chk("swapped", swapped, q[0].sw);
        void'(q.pop_front());
        seen = 1'b0;
      end
    end
  end

  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic opv,
                       input logic [26:0] mb, input logic [26:0] ms, input logic [7:0] eb,
                       input logic sb, input logic es, input logic sw, input int lat);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_wait", in_ready, 1);
    a = av; b = bv; op = opv; in_valid = 1'b1;
    @(posedge clk); #1;
    e.mb = mb; e.ms = ms; e.eb = eb; e.sb = sb; e.es = es; e.sw = sw;
    e.lat = lat; e.acc = cyc;
    q.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); n++;
    end
    chk("drain", q.size(), 0);
    @(posedge clk); #1;
  endtask

  logic [26:0] snap_mb, snap_ms;
  logic [7:0]  snap_eb;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_man_big", man_big, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(32'h3F800000, 32'h3F000000, 1'b0, 27'h4000000, 27'h2000000, 8'h7F, 1'b0, 1'b0, 1'b0, 2);
    wait_done();
    issue(32'h3F000000, 32'h3F800000, 1'b1, 27'h4000000, 27'h2000000, 8'h7F, 1'b1, 1'b1, 1'b1, 2);
    wait_done();
    issue(32'h4B800000, 32'h3F800001, 1'b0, 27'h4000000, 27'h0000005, 8'h97, 1'b0, 1'b0, 1'b0, 25);
    wait_done();
    issue(32'h64000000, 32'h3F800000, 1'b0, 27'h4000000, 27'h0000001, 8'hC8, 1'b0, 1'b0, 1'b0, 27);
    wait_done();
    issue(32'h64000000, 32'h00000000, 1'b0, 27'h4000000, 27'h0000000, 8'hC8, 1'b0, 1'b0, 1'b0, 27);
    wait_done();
    issue(32'h40400000, 32'h40400000, 1'b1, 27'h6000000, 27'h6000000, 8'h80, 1'b0, 1'b1, 1'b0, 1);
    wait_done();
    issue(32'h00000000, 32'h80000000, 1'b0, 27'h0000000, 27'h0000000, 8'h01, 1'b0, 1'b1, 1'b0, 1);
    wait_done();
    issue(32'hC0000000, 32'h3F800000, 1'b0, 27'h4000000, 27'h2000000, 8'h80, 1'b1, 1'b1, 1'b0, 2);
    wait_done();
    issue(32'h7F800000, 32'h3F800000, 1'b0, 27'h4000000, 27'h0000001, 8'hFF, 1'b0, 1'b0, 1'b0, 27);
    wait_done();

    // Denormal pair with downstream back-pressure.
    out_ready = 1'b0;
    issue(32'h00800000, 32'h00000001, 1'b0, 27'h4000000, 27'h0000008, 8'h01, 1'b0, 1'b0, 1'b0, 1);
    chk("hold_out_valid", out_valid, 1);
    snap_mb = man_big; snap_ms = man_small; snap_eb = exp_base;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid_stable", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_man_small", man_small, snap_ms);
      chk("hold_man_big", man_big, snap_mb);
      chk("hold_exp_base", exp_base, snap_eb);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
    chk("release_drained", q.size(), 0);

    // Reset in the middle of a long shift.
    issue(32'h64000000, 32'h3F800000, 1'b0, 27'h4000000, 27'h0000001, 8'hC8, 1'b0, 1'b0, 1'b0, 27);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_man_big", man_big, 0);
    chk("abort_man_small", man_small, 0);
    chk("abort_exp_base", exp_base, 0);
    chk("abort_flags", {sign_big, eff_sub, swapped}, 0);
    chk("abort_in_ready", in_ready, 1);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    issue(32'h3F800000, 32'h3F000000, 1'b0, 27'h4000000, 27'h2000000, 8'h7F, 1'b0, 1'b0, 1'b0, 2);
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
